// File: rtl/vector_list_sequencer.sv
// Walks the vector-image ROM once per frame and streams translated points to the line drawer.
// Optional build macro VSEQ_CLIP_EN: translated coordinates saturate at 255 instead of wrapping.
module vector_list_sequencer #(
  parameter int          ADDRESSWIDTH = 16,
  parameter int          DATAWIDTH    = 18,
  parameter int unsigned BASE0        = 0,
  parameter int unsigned BASE1        = 42,
  parameter int unsigned BASE2        = 48,
  parameter int unsigned BASE3        = 54,
  parameter int          MAX_OBJ_LEN  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic [3:0]              obj_en,
  input  logic [31:0]             off_x,
  input  logic [31:0]             off_y,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic                    pt_valid,
  input  logic                    pt_ready,
  output logic [7:0]              pt_x,
  output logic [7:0]              pt_y,
  output logic                    pt_line,
  output logic                    pt_last,
  output logic [1:0]              pt_obj,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    err_runaway
);

  localparam int                    CW       = $clog2(MAX_OBJ_LEN + 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_LAST = CW'(MAX_OBJ_LEN - 1);
  localparam logic [ADDRESSWIDTH-1:0] ADDR_ONE = ADDRESSWIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    FETCH  = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_r;
  logic [3:0]              pending_r;
  logic [31:0]             offx_r;
  logic [31:0]             offy_r;
  logic [CW-1:0]           cnt_r;

  logic [1:0]              sel_s;
  logic                    sel_found_s;
  logic [ADDRESSWIDTH-1:0] base_s;
  logic [7:0]              wx_s;
  logic [7:0]              wy_s;
  logic                    wline_s;
  logic                    wpos_s;
  logic [7:0]              ox_s;
  logic [7:0]              oy_s;

  function automatic logic [7:0] translate(input logic [7:0] v, input logic [7:0] off);
`ifdef VSEQ_CLIP_EN
    logic [8:0] sum;
    sum = {1'b0, v} + {1'b0, off};
    translate = sum[8] ? 8'hFF : sum[7:0];
`else
    translate = v + off;
`endif
  endfunction

  assign wx_s    = rom_data[DATAWIDTH-1 -: 8];
  assign wy_s    = rom_data[DATAWIDTH-9 -: 8];
  assign wline_s = rom_data[1];
  assign wpos_s  = rom_data[0];
  assign ox_s    = offx_r[{pt_obj, 3'b000} +: 8];
  assign oy_s    = offy_r[{pt_obj, 3'b000} +: 8];

  // Lowest-index enabled object that has not been walked yet this frame.
  always_comb begin
    sel_s       = 2'd0;
    sel_found_s = 1'b1;
    if (pending_r[0]) begin
      sel_s = 2'd0;
    end else if (pending_r[1]) begin
      sel_s = 2'd1;
    end else if (pending_r[2]) begin
      sel_s = 2'd2;
    end else if (pending_r[3]) begin
      sel_s = 2'd3;
    end else begin
      sel_found_s = 1'b0;
    end
  end

  // First ROM address of the selected object.
  always_comb begin
    case (sel_s)
      2'd0:    base_s = ADDRESSWIDTH'(BASE0);
      2'd1:    base_s = ADDRESSWIDTH'(BASE1);
      2'd2:    base_s = ADDRESSWIDTH'(BASE2);
      2'd3:    base_s = ADDRESSWIDTH'(BASE3);
      default: base_s = ADDRESSWIDTH'(BASE0);
    endcase
  end

  // Walk sequencer; every output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pending_r   <= 4'd0;
      offx_r      <= 32'd0;
      offy_r      <= 32'd0;
      cnt_r       <= '0;
      rom_addr    <= '0;
      pt_valid    <= 1'b0;
      pt_x        <= 8'd0;
      pt_y        <= 8'd0;
      pt_line     <= 1'b0;
      pt_last     <= 1'b0;
      pt_obj      <= 2'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      err_runaway <= 1'b0;
    end else begin
      overrun    <= frame_start && (state_r != IDLE);
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            pending_r <= obj_en;
            offx_r    <= off_x;
            offy_r    <= off_y;
            busy      <= 1'b1;
            state_r   <= SELECT;
          end
        end
        SELECT: begin
          if (sel_found_s) begin
            rom_addr         <= base_s;
            cnt_r            <= '0;
            pt_obj           <= sel_s;
            pending_r[sel_s] <= 1'b0;
            state_r          <= FETCH;
          end else begin
            frame_done <= 1'b1;
            state_r    <= DONE;
          end
        end
        FETCH: begin
          cnt_r <= cnt_r + CNT_ONE;
          // An end marker on the last allowed entry still closes the object normally.
          if (wline_s && wpos_s) begin
            pt_x     <= translate(wx_s, ox_s);
            pt_y     <= translate(wy_s, oy_s);
            pt_line  <= wline_s;
            pt_last  <= 1'b1;
            pt_valid <= 1'b1;
            state_r  <= EMIT;
          end else if (cnt_r == CNT_LAST) begin
            err_runaway <= 1'b1;
            state_r     <= SELECT;
          end else if (!wline_s && !wpos_s) begin
            rom_addr <= rom_addr + ADDR_ONE;
          end else begin
            pt_x     <= translate(wx_s, ox_s);
            pt_y     <= translate(wy_s, oy_s);
            pt_line  <= wline_s;
            pt_last  <= 1'b0;
            pt_valid <= 1'b1;
            state_r  <= EMIT;
          end
        end
        EMIT: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            if (pt_last) begin
              state_r <= SELECT;
            end else begin
              rom_addr <= rom_addr + ADDR_ONE;
              state_r  <= FETCH;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Randomized self-checking bench for vector_list_sequencer against a list-walking reference model.
`timescale 1ns/1ps
module tb_vector_list_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  obj_en = 4'd0;
  logic [31:0] off_x = 32'd0;
  logic [31:0] off_y = 32'd0;
  logic [15:0] rom_addr;
  logic [17:0] rom_data;
  logic        pt_valid;
  logic        pt_ready = 1'b0;
  logic [7:0]  pt_x, pt_y;
  logic        pt_line, pt_last;
  logic [1:0]  pt_obj;
  logic        busy, frame_done, overrun, err_runaway;

  logic [17:0] mem [0:255];
  int          base_a [4] = '{0, 42, 48, 54};
  logic [19:0] exp_q [$];
  bit          exp_err = 1'b0;
  int          checks = 0;
  int          errors = 0;

  vector_list_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .obj_en(obj_en),
    .off_x(off_x), .off_y(off_y), .rom_addr(rom_addr), .rom_data(rom_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .pt_line(pt_line), .pt_last(pt_last), .pt_obj(pt_obj), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .err_runaway(err_runaway)
  );

  assign rom_data = (rom_addr < 16'd256) ? mem[rom_addr[7:0]] : 18'd0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] w(input int x, input int y, input bit ln, input bit ps);
    return {8'(x), 8'(y), ln, ps};
  endfunction

  function automatic logic [7:0] xlate(input int v, input int off);
    int s;
    s = v + off;
`ifdef VSEQ_CLIP_EN
    if (s > 255) s = 255;
`endif
    return 8'(s % 256);
  endfunction

  function automatic logic [17:0] rand_word(input bit marker);
    int r;
    r = $urandom_range(5);
    if (marker) return w($urandom_range(255), $urandom_range(255), 1'b1, 1'b1);
    if (r == 0) return w($urandom_range(255), $urandom_range(255), 1'b0, 1'b0);
    if (r < 3)  return w($urandom_range(255), $urandom_range(255), 1'b0, 1'b1);
    return w($urandom_range(255), $urandom_range(255), 1'b1, 1'b0);
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 18'd0;
  endtask

  task automatic fill_random();
    clear_mem();
    for (int n = 0; n < 4; n++) begin
      int span, len;
      bit term;
      span = (n == 3) ? 70 : base_a[n+1] - base_a[n];
      len  = $urandom_range(span, 1);
      term = ($urandom_range(7) != 0);
      for (int i = 0; i < len; i++) mem[base_a[n] + i] = rand_word((i == len - 1) && term);
    end
  endtask

  // Reference: each enabled object is a list of up to 64 entries ending at its marker.
  task automatic build_model(input logic [3:0] en, input logic [31:0] ox, input logic [31:0] oy,
                             output bit first_direct);
    bit first;
    first_direct = 1'b0;
    first = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (en[n]) begin
        int addr;
        addr = base_a[n];
        for (int k = 1; k <= 64; k++) begin
          logic [17:0] wd;
          wd = mem[addr];
          if (first) begin
            first_direct = wd[1] | wd[0];
            first = 1'b0;
          end
          if (wd[1] && wd[0]) begin
            exp_q.push_back({2'(n), 1'b1, 1'b1, xlate(int'(wd[17:10]), int'(ox[8*n +: 8])),
                             xlate(int'(wd[9:2]), int'(oy[8*n +: 8]))});
            break;
          end
          if (k == 64) begin
            exp_err = 1'b1;
            break;
          end
          if (wd[1] || wd[0])
            exp_q.push_back({2'(n), 1'b0, wd[1], xlate(int'(wd[17:10]), int'(ox[8*n +: 8])),
                             xlate(int'(wd[9:2]), int'(oy[8*n +: 8]))});
          addr++;
        end
      end
    end
  endtask

  task automatic run_frame(input logic [3:0] en, input logic [31:0] ox, input logic [31:0] oy,
                           input int ready_pct, input bit want_ov);
    bit first_direct, ov, done_seen, prev_stall;
    int k, first_k, done_k, n_exp, n_got;
    logic [19:0] pay, prev_pay;
    exp_q.delete();
    build_model(en, ox, oy, first_direct);
    n_exp = exp_q.size();
    n_got = 0;
    ov = want_ov && (n_exp >= 4);
    @(negedge clk);
    obj_en = en; off_x = ox; off_y = oy; frame_start = 1'b1;
    k = 0; first_k = -1; done_k = -1; done_seen = 1'b0; prev_stall = 1'b0; prev_pay = '0;
    while (!done_seen && k < 2000) begin
      @(negedge clk);
      k++;
      frame_start = 1'b0;
      if (ov && k == 5) begin
        frame_start = 1'b1;
        obj_en = ~en; off_x = $urandom; off_y = $urandom;
      end
      pt_ready = ($urandom_range(99) < ready_pct);
      pay = {pt_obj, pt_last, pt_line, pt_x, pt_y};
      check_eq("overrun", overrun, ov && (k == 6));
      check_eq("busy", busy, 1'b1);
      if (prev_stall) check_eq("stall_hold", {pt_valid, pay}, {1'b1, prev_pay});
      if (pt_valid) begin
        if (first_k < 0) first_k = k;
        if (pt_ready) begin
          n_got++;
          if (exp_q.size() > 0) check_eq("point", pay, exp_q.pop_front());
        end
      end
      prev_stall = pt_valid && !pt_ready;
      prev_pay = pay;
      if (frame_done) begin
        done_seen = 1'b1;
        done_k = k;
      end
    end
    check_eq("frame_done_seen", done_seen, 1'b1);
    check_eq("point_count", n_got, n_exp);
    check_eq("err_runaway", err_runaway, exp_err);
    if (en == 4'd0) check_eq("empty_done_lat", done_k, 2);
    if (first_direct) check_eq("first_pt_lat", first_k, 3);
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("done_pulse", frame_done, 1'b0);
    obj_en = en;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_start = 1'b0; pt_ready = 1'b0;
    obj_en = 4'd0; off_x = 32'd0; off_y = 32'd0;
    exp_err = 1'b0;
    #1;
    check_eq("reset_addr", rom_addr, 16'd0);
    check_eq("reset_outs", {pt_valid, pt_x, pt_y, pt_line, pt_last, pt_obj, busy, frame_done,
                            overrun, err_runaway}, 25'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Frame outline at 42..47, no offsets.
    clear_mem();
    mem[42] = w(0, 254, 1'b0, 1'b1);  mem[43] = w(0, 0, 1'b1, 1'b0);
    mem[44] = w(254, 0, 1'b1, 1'b0);  mem[45] = w(254, 254, 1'b1, 1'b0);
    mem[46] = w(0, 254, 1'b1, 1'b0);  mem[47] = w(0, 254, 1'b1, 1'b1);
    run_frame(4'b0010, 32'd0, 32'd0, 100, 1'b0);

    // Bomber with x=255 near the edge, hole at 68, marker at 69.
    for (int a = 54; a < 68; a++) mem[a] = w((a == 54) ? 255 : a, 100, a != 54, a == 54);
    mem[68] = 18'd0;
    mem[69] = w(255, 100, 1'b1, 1'b1);
    run_frame(4'b1000, 32'h0800_0000, 32'd0, 100, 1'b0);
    run_frame(4'b0000, 32'd0, 32'd0, 100, 1'b0);

    // Full map under backpressure.
    fill_random();
    for (int a = 0; a < 41; a++) mem[a] = rand_word(1'b0);
    mem[41] = rand_word(1'b1);
    run_frame(4'b0001, $urandom, $urandom, 50, 1'b1);

    for (int f = 0; f < 30; f++) begin
      fill_random();
      run_frame(4'($urandom_range(15)), $urandom, $urandom,
                ($urandom_range(1) == 1) ? 100 : 50, $urandom_range(3) == 0);
    end

    // Runaway boundary: marker as entry 64 is accepted, as entry 65 it is not.
    apply_reset();
    clear_mem();
    for (int a = 54; a < 117; a++) mem[a] = rand_word(1'b0);
    for (int a = 54; a < 117; a++) if (mem[a][1:0] == 2'b00) mem[a][0] = 1'b1;
    mem[117] = rand_word(1'b1);
    run_frame(4'b1000, $urandom, $urandom, 100, 1'b0);
    mem[117] = w(1, 2, 1'b1, 1'b0);
    mem[118] = rand_word(1'b1);
    run_frame(4'b1000, $urandom, $urandom, 50, 1'b0);
    apply_reset();
    clear_mem();
    mem[0] = w(5, 6, 1'b0, 1'b1);
    mem[1] = w(7, 8, 1'b1, 1'b1);
    run_frame(4'b1001, $urandom, $urandom, 100, 1'b0);

    // Reset in the middle of a walk.
    fill_random();
    for (int a = 0; a < 10; a++) mem[a] = w(a, a, 1'b1, 1'b0);
    mem[10] = rand_word(1'b1);
    @(negedge clk);
    obj_en = 4'b0001; frame_start = 1'b1; pt_ready = 1'b1;
    for (int i = 0; i < 10 && !pt_valid; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
    end
    check_eq("pre_reset_valid", pt_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", pt_valid, 1'b0);
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_addr", rom_addr, 16'd0);
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_frame(4'b1111, $urandom, $urandom, 50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
